mc_control_unit: RTL and testbench

Multicycle control FSM for the 24-bit processor core. It sequences every instruction through IF/ID/EX/MEM/WB, decodes the latched IR into datapath control strobes, and evaluates the EQ/NE predicate against the Z flag. It sits directly upstream of the datapath and drives its state, mux-select, ALU and memory-strobe inputs. It also owns the Z flag and the performance counters that the datapath bench prints.

---
 rtl/mc_ctrl_pkg.sv | 77 +++++++
 rtl/mc_control_unit_decode.sv | 46 ++++
 rtl/mc_control_unit.sv | 166 ++++++++++++++++
 tb/tb_mc_control_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, ALU/PC/WB
// select codes, condition codes and the decoded-path record.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'b000,
        ST_ID  = 3'b001,
        ST_EX  = 3'b010,
        ST_MEM = 3'b011,
        ST_WB  = 3'b100
    } state_t;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_CMP  = 5'b00011;
    localparam logic [4:0] OP_CAS  = 5'b00100;
    localparam logic [4:0] OP_LUI  = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b00110;
    localparam logic [4:0] OP_LWS  = 5'b00111;
    localparam logic [4:0] OP_SW   = 5'b01000;
    localparam logic [4:0] OP_BEQ  = 5'b01001;
    localparam logic [4:0] OP_J    = 5'b01010;
    localparam logic [4:0] OP_JR   = 5'b01011;
    localparam logic [4:0] OP_JAL  = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ADDI = 5'b01110;
    localparam logic [4:0] OP_SUBI = 5'b01111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_MAX = 3'b011;
    localparam logic [2:0] ALU_CMP = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    localparam logic [1:0] COND_AL = 2'b00;
    localparam logic [1:0] COND_EQ = 2'b01;
    localparam logic [1:0] COND_NE = 2'b10;
    localparam logic [1:0] COND_NV = 2'b11;

    typedef struct packed {
        logic       needs_ex;
        logic       needs_mem;
        logic       needs_wb;
        logic       is_imm;
        logic       is_branch;
        logic       is_jump;
        logic       is_jr;
        logic       is_jal;
        logic       is_load;
        logic       is_store;
        logic       illegal;
        logic [2:0] alu_op;
    } decode_t;

    function automatic logic cond_pass(input logic [1:0] cond, input logic z);
        logic p;
        case (cond)
            COND_AL: p = 1'b1;
            COND_EQ: p = z;
            COND_NE: p = ~z;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mc_control_unit_decode.sv
// Opcode-to-path decoder: tells the FSM which stages an instruction visits and
// which ALU function and operand source it needs.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    output decode_t    dec_o
);

    always_comb begin
        dec_o        = '0;
        dec_o.alu_op = ALU_AND;
        case (opcode_i)
            OP_AND:  begin dec_o.needs_ex = 1'b1; dec_o.needs_wb = 1'b1; dec_o.alu_op = ALU_AND; end
            OP_ADD:  begin dec_o.needs_ex = 1'b1; dec_o.needs_wb = 1'b1; dec_o.alu_op = ALU_ADD; end
            OP_SUB:  begin dec_o.needs_ex = 1'b1; dec_o.needs_wb = 1'b1; dec_o.alu_op = ALU_SUB; end
            OP_CMP:  begin dec_o.needs_ex = 1'b1; dec_o.needs_wb = 1'b1; dec_o.alu_op = ALU_CMP; end
            OP_CAS:  begin dec_o.needs_ex = 1'b1; dec_o.needs_wb = 1'b1; dec_o.alu_op = ALU_MAX; end
            OP_ANDI: begin dec_o.needs_ex = 1'b1; dec_o.needs_wb = 1'b1; dec_o.is_imm = 1'b1; dec_o.alu_op = ALU_AND; end
            OP_ADDI: begin dec_o.needs_ex = 1'b1; dec_o.needs_wb = 1'b1; dec_o.is_imm = 1'b1; dec_o.alu_op = ALU_ADD; end
            OP_SUBI: begin dec_o.needs_ex = 1'b1; dec_o.needs_wb = 1'b1; dec_o.is_imm = 1'b1; dec_o.alu_op = ALU_SUB; end
            OP_LUI:  begin dec_o.needs_ex = 1'b1; dec_o.needs_wb = 1'b1; dec_o.is_imm = 1'b1; dec_o.alu_op = ALU_SHL; end
            OP_LW, OP_LWS: begin
                dec_o.needs_ex  = 1'b1;
                dec_o.needs_mem = 1'b1;
                dec_o.needs_wb  = 1'b1;
                dec_o.is_imm    = 1'b1;
                dec_o.is_load   = 1'b1;
                dec_o.alu_op    = ALU_ADD;
            end
            OP_SW: begin
                dec_o.needs_ex  = 1'b1;
                dec_o.needs_mem = 1'b1;
                dec_o.is_imm    = 1'b1;
                dec_o.is_store  = 1'b1;
                dec_o.alu_op    = ALU_ADD;
            end
            OP_BEQ:  begin dec_o.needs_ex = 1'b1; dec_o.is_branch = 1'b1; dec_o.alu_op = ALU_SUB; end
            OP_J:    begin dec_o.is_jump = 1'b1; end
            OP_JR:   begin dec_o.is_jump = 1'b1; dec_o.is_jr = 1'b1; end
            OP_JAL:  begin dec_o.is_jump = 1'b1; dec_o.is_jal = 1'b1; dec_o.needs_wb = 1'b1; end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle IF/ID/EX/MEM/WB control FSM with predication and Z flag.
// Optional performance counters are built only when CTRL_PERF_CNT_EN is defined.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter bit IMEM_WAIT_EN_DEFAULT = 1'b0,
    parameter int CNT_W                = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [23:0]      ir,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic [2:0]       next_state,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [1:0]       pc_src,
    output logic             alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       wb_src,
    output logic             reg_dst_r7,
    output logic             z_flag,
    output logic             illegal_op,
    output logic [CNT_W-1:0] ins_count,
    output logic [CNT_W-1:0] cpi_last
);

    state_t  state_q, state_d;
    logic    z_q, z_d;
    decode_t dec;
    logic    pass;
    logic    imem_done;
    logic    unused_fields;

    assign pass          = cond_pass(ir[23:22], z_q);
    assign imem_done     = !IMEM_WAIT_EN_DEFAULT || imem_ready;
    assign unused_fields = ^ir[15:0];

    mc_decode u_decode (
        .opcode_i (ir[21:17]),
        .dec_o    (dec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF:  if (imem_done) state_d = ST_ID;
            ST_ID: begin
                if (!pass || dec.illegal) state_d = ST_IF;
                else if (dec.needs_ex)    state_d = ST_EX;
                else if (dec.needs_wb)    state_d = ST_WB;
                else                      state_d = ST_IF;
            end
            ST_EX: begin
                if (dec.needs_mem)     state_d = ST_MEM;
                else if (dec.needs_wb) state_d = ST_WB;
                else                   state_d = ST_IF;
            end
            ST_MEM: if (dmem_ready) state_d = dec.needs_wb ? ST_WB : ST_IF;
            ST_WB:  state_d = ST_IF;
            default: state_d = ST_IF;
        endcase
    end

    // Only executing instructions reach EX, so the predicate needs no re-check here.
    assign z_d = (state_q == ST_EX && ir[16]) ? alu_zero : z_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IF;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    assign state      = state_q;
    assign next_state = reset ? state_d : ST_IF;
    assign z_flag     = z_q;

    // reset is active-low: strobes are forced off while it is asserted so a
    // pending memory access drops immediately, not at the next edge.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        pc_src     = PC_SEQ;
        alu_src_b  = 1'b0;
        alu_op     = ALU_AND;
        wb_src     = WB_ALU;
        reg_dst_r7 = 1'b0;
        illegal_op = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IF: begin
                    ir_write = imem_done;
                    pc_write = imem_done;
                end
                ST_ID: begin
                    illegal_op = dec.illegal;
                    if (!pass || dec.illegal) begin
                        pc_write = 1'b1;
                    end else if (dec.is_jump) begin
                        pc_write = 1'b1;
                        pc_src   = dec.is_jr ? PC_REG : PC_JUMP;
                    end
                end
                ST_EX: begin
                    alu_op    = dec.alu_op;
                    alu_src_b = dec.is_imm;
                    if (dec.is_branch) begin
                        pc_write = alu_zero;
                        pc_src   = PC_BRANCH;
                    end
                end
                ST_MEM: begin
                    mem_rd = dec.is_load;
                    mem_wr = dec.is_store;
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    reg_dst_r7 = dec.is_jal;
                    wb_src     = dec.is_load ? WB_MEM : (dec.is_jal ? WB_PC : WB_ALU);
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] ins_q, cpi_q, cyc_q;
    logic             retire;

    assign retire = (state_q != ST_IF) && (state_d == ST_IF);

    // cyc_q counts cycles already spent on the current instruction, stalls included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ins_q <= '0;
            cpi_q <= '0;
            cyc_q <= '0;
        end else if (retire) begin
            ins_q <= ins_q + 1'b1;
            cpi_q <= cyc_q + 1'b1;
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign ins_count = ins_q;
    assign cpi_last  = cpi_q;
`else
    assign ins_count = '0;
    assign cpi_last  = '0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: an instruction-level model expands each
// instruction into expected per-cycle outputs; a monitor compares at negedge.
`timescale 1ns/1ps
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    localparam int CW = 32;
    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [23:0]   ir = '0;
    logic          alu_zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic [2:0]    state, next_state;
    logic          ir_write, pc_write, reg_write, mem_rd, mem_wr;
    logic [1:0]    pc_src, wb_src;
    logic          alu_src_b, reg_dst_r7, z_flag, illegal_op;
    logic [2:0]    alu_op;
    logic [CW-1:0] ins_count, cpi_last;

    always #5 clk = ~clk;

    mc_control_unit #(.IMEM_WAIT_EN_DEFAULT(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ir(ir), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .state(state), .next_state(next_state), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_src(pc_src),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_src(wb_src), .reg_dst_r7(reg_dst_r7),
        .z_flag(z_flag), .illegal_op(illegal_op), .ins_count(ins_count), .cpi_last(cpi_last)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic [2:0]    nx;
        logic          irW, pcW, regW, mRd, mWr;
        logic [1:0]    pcS;
        logic          bSel;
        logic [2:0]    aOp;
        logic [1:0]    wbS;
        logic          r7, ill, z;
        logic [CW-1:0] ins, cpi;
    } obs_t;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_BEQ, K_J, K_JR, K_JAL, K_ILL} kind_t;

    obs_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycNo = 0;

    bit          zM = 1'b0;
    int unsigned insM = 0;
    int unsigned cpiM = 0;

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d nx=%0d irw=%0b pcw=%0b rw=%0b mrd=%0b mwr=%0b pcs=%0d bsel=%0b aop=%0d wbs=%0d r7=%0b ill=%0b z=%0b ins=%0d cpi=%0d",
                         o.st, o.nx, o.irW, o.pcW, o.regW, o.mRd, o.mWr, o.pcS, o.bSel,
                         o.aOp, o.wbS, o.r7, o.ill, o.z, o.ins, o.cpi);
    endfunction

    function automatic obs_t sampleDut();
        obs_t a;
        a.st = state;       a.nx = next_state;
        a.irW = ir_write;   a.pcW = pc_write;   a.regW = reg_write;
        a.mRd = mem_rd;     a.mWr = mem_wr;     a.pcS = pc_src;
        a.bSel = alu_src_b; a.aOp = alu_op;     a.wbS = wb_src;
        a.r7 = reg_dst_r7;  a.ill = illegal_op; a.z = z_flag;
        a.ins = ins_count;  a.cpi = cpi_last;
        return a;
    endfunction

    task automatic checkOutput(input string name, input obs_t e);
        obs_t a;
        a = sampleDut();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL %s: got {%s} expected {%s}", name, fmt(a), fmt(e));
        end
    endtask

    function automatic kind_t classify(input logic [4:0] op);
        case (op)
            OP_LW, OP_LWS: return K_LOAD;
            OP_SW:         return K_STORE;
            OP_BEQ:        return K_BEQ;
            OP_J:          return K_J;
            OP_JR:         return K_JR;
            OP_JAL:        return K_JAL;
            default:       return (op[4]) ? K_ILL : K_ALU;
        endcase
    endfunction

    function automatic logic [2:0] aluFor(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_LWS, OP_SW: return ALU_ADD;
            OP_SUB, OP_SUBI, OP_BEQ:               return ALU_SUB;
            OP_CMP:                                return ALU_CMP;
            OP_CAS:                                return ALU_MAX;
            OP_LUI:                                return ALU_SHL;
            default:                               return ALU_AND;
        endcase
    endfunction

    function automatic bit isImm(input logic [4:0] op);
        return op inside {OP_ANDI, OP_ADDI, OP_SUBI, OP_LUI, OP_LW, OP_LWS, OP_SW};
    endfunction

    function automatic logic [23:0] mk(input logic [1:0] c, input logic [4:0] op, input logic sf);
        logic [2:0] rd, rs, rt;
        rd = 3'($urandom_range(0, 7));
        rs = 3'($urandom_range(0, 7));
        rt = 3'($urandom_range(0, 7));
        return {c, op, sf, rd, rs, rt, 7'b0};
    endfunction

    task automatic applyReset(input string name);
        reset = 1'b0;
        #1;
        checkOutput({name, " async"}, '0);
        @(posedge clk); #1;
        checkOutput({name, " held"}, '0);
        reset = 1'b1;
        zM = 1'b0; insM = 0; cpiM = 0;
    endtask

    // Expand one instruction into its stage list and push one expected record per cycle.
    task automatic applyStimulus(input logic [23:0] instr, input int imemStall,
                                 input int dmemStall, input int az, input bit abortMem);
        logic [4:0] op;
        kind_t      kind;
        bit         exec, done;
        logic [2:0] path[$];
        logic [2:0] s, nextS;
        int         stall, cyc;
        obs_t       e;
        op   = instr[21:17];
        kind = classify(op);
        case (instr[23:22])
            2'b00:   exec = 1'b1;
            2'b01:   exec = zM;
            2'b10:   exec = !zM;
            default: exec = 1'b0;
        endcase
        path = '{S_IF, S_ID};
        if (exec) begin
            case (kind)
                K_ALU:   begin path.push_back(S_EX); path.push_back(S_WB); end
                K_LOAD:  begin path.push_back(S_EX); path.push_back(S_MEM); path.push_back(S_WB); end
                K_STORE: begin path.push_back(S_EX); path.push_back(S_MEM); end
                K_BEQ:   path.push_back(S_EX);
                K_JAL:   path.push_back(S_WB);
                default: ;
            endcase
        end
        ir  = instr;
        cyc = 0;
        for (int k = 0; k < path.size(); k++) begin
            s     = path[k];
            nextS = (k + 1 < path.size()) ? path[k+1] : S_IF;
            stall = (s == S_IF) ? imemStall : ((s == S_MEM) ? dmemStall : 0);
            for (int w = 0; w <= stall; w++) begin
                done       = (w == stall);
                imem_ready = (s == S_IF)  ? done : 1'($urandom_range(0, 1));
                dmem_ready = (s == S_MEM) ? done : 1'($urandom_range(0, 1));
                alu_zero   = (az < 0) ? 1'($urandom_range(0, 1)) : az[0];
                e     = '0;
                e.st  = s;
                e.nx  = done ? nextS : s;
                e.z   = zM;
`ifdef CTRL_PERF_CNT_EN
                e.ins = insM;
                e.cpi = cpiM;
`endif
                case (s)
                    S_IF: begin e.irW = done; e.pcW = done; end
                    S_ID: begin
                        e.ill = (kind == K_ILL);
                        if (!exec || kind == K_ILL) e.pcW = 1'b1;
                        else if (kind == K_J || kind == K_JAL) begin e.pcW = 1'b1; e.pcS = PC_JUMP; end
                        else if (kind == K_JR) begin e.pcW = 1'b1; e.pcS = PC_REG; end
                    end
                    S_EX: begin
                        e.aOp  = aluFor(op);
                        e.bSel = isImm(op);
                        if (kind == K_BEQ) begin e.pcW = alu_zero; e.pcS = PC_BRANCH; end
                    end
                    S_MEM: begin e.mRd = (kind == K_LOAD); e.mWr = (kind == K_STORE); end
                    default: begin
                        e.regW = 1'b1;
                        e.r7   = (kind == K_JAL);
                        e.wbS  = (kind == K_LOAD) ? WB_MEM : ((kind == K_JAL) ? WB_PC : WB_ALU);
                    end
                endcase
                expQ.push_back(e);
                cyc++;
                if (abortMem && s == S_MEM) begin
                    @(negedge clk); #1;
                    applyReset("reset during MEM");
                    return;
                end
                @(posedge clk); #1;
                if (s == S_EX && instr[16]) zM = alu_zero;
                if (done && nextS == S_IF) begin
                    insM++;
                    cpiM = cyc;
                end
            end
        end
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput($sformatf("cycle %0d", cycNo), e);
            end
            cycNo++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [1:0] c;
        logic [4:0] op;
        #2;
        checkOutput("initial reset", '0);
        @(posedge clk); #1;
        reset = 1'b1;

        applyStimulus(mk(COND_AL, OP_ADD, 1'b0), 0, 0, -1, 1'b0);
        applyStimulus(mk(COND_AL, OP_LW,  1'b0), 0, 2, -1, 1'b0);
        applyStimulus(mk(COND_AL, OP_SUB, 1'b1), 0, 0,  1, 1'b0);
        applyStimulus(mk(COND_AL, OP_BEQ, 1'b0), 0, 0,  1, 1'b0);
        applyStimulus(mk(COND_AL, OP_SUB, 1'b1), 1, 0,  0, 1'b0);
        applyStimulus(mk(COND_EQ, OP_ADD, 1'b0), 0, 0, -1, 1'b0);
        applyStimulus(mk(COND_AL, OP_JAL, 1'b0), 0, 0, -1, 1'b0);
        applyStimulus(mk(COND_AL, OP_JR,  1'b0), 2, 0, -1, 1'b0);
        applyStimulus(mk(COND_AL, 5'b10101, 1'b0), 0, 0, -1, 1'b0);
        applyStimulus(mk(COND_NV, OP_ADD, 1'b0), 0, 0, -1, 1'b0);
        applyStimulus(mk(COND_AL, OP_SW,  1'b0), 0, 3, -1, 1'b1);
        applyStimulus(mk(COND_AL, OP_SW,  1'b0), 0, 1, -1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            c  = 2'($urandom_range(0, 3));
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
            applyStimulus(mk(c, op, 1'($urandom_range(0, 1))), $urandom_range(0, 2),
                          $urandom_range(0, 2), -1, 1'b0);
        end
        applyStimulus(mk(COND_AL, OP_LWS, 1'b1), 0, 0, -1, 1'b0);

        @(negedge clk); #1;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
